// File: rtl/layer_output_collector.sv
// layer_output_collector
//  Purpose : packs the serial output beats of the last neuron layer into one
//            NEURON_NB*WIDTH frame and sequences the arg-max selector
//            (enable -> wait done -> clear) before accepting the next frame.
//  Ports   : clk/reset (async, active-high); in_valid/in_ready/in_data/in_last
//            upstream beat handshake; max_enable/max_done/max_clear selector
//            sequencing; out_data packed frame (slot k at [WIDTH*k +: WIDTH]);
//            frame_cnt frames delivered (wraps); frame_err sticky framing error.
//  Timing  : max_enable rises the cycle after the final beat is accepted; the
//            first beat of the next frame is accepted at the earliest 2 cycles
//            after max_done is sampled. All outputs are registered.
module layer_output_collector #(
  parameter int NEURON_NB = 10,
  parameter int WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       max_enable,
  input  logic                       max_done,
  output logic                       max_clear,
  output logic [WIDTH*NEURON_NB-1:0] out_data,
  output logic [7:0]                 frame_cnt,
  output logic                       frame_err
);

  localparam int PTR_W = $clog2(NEURON_NB);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NEURON_NB - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      ptr        <= '0;
      in_ready   <= 1'b1;
      max_enable <= 1'b0;
      max_clear  <= 1'b0;
      out_data   <= '0;
      frame_cnt  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // in_ready is always high in this state, so it doubles as the
          // acceptance qualifier.
          if (in_valid && in_ready) begin
            for (int k = 0; k < NEURON_NB; k++) begin
              if (PTR_W'(k) == ptr) begin
                out_data[WIDTH*k +: WIDTH] <= in_data;
              end else if (in_last && (PTR_W'(k) > ptr)) begin
                // Short frame: slots past the final beat must read as zero.
                out_data[WIDTH*k +: WIDTH] <= '0;
              end
            end
            if (in_last || (ptr == PTR_LAST)) begin
              state      <= FULL;
              in_ready   <= 1'b0;
              max_enable <= 1'b1;
              // Well-formed frame: in_last exactly on the last slot. Any
              // other way of ending the frame is a framing error.
              if (in_last != (ptr == PTR_LAST)) begin
                frame_err <= 1'b1;
              end
            end else begin
              ptr <= ptr + PTR_ONE;
            end
          end
        end

        FULL: begin
          if (max_done) begin
            state      <= CLEAR;
            max_enable <= 1'b0;
            max_clear  <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            out_data   <= '0;
            ptr        <= '0;
          end
        end

        CLEAR: begin
          state     <= COLLECT;
          max_clear <= 1'b0;
          in_ready  <= 1'b1;
        end

        default: begin
          state      <= COLLECT;
          ptr        <= '0;
          in_ready   <= 1'b1;
          max_enable <= 1'b0;
          max_clear  <= 1'b0;
        end
      endcase
    end
  end

endmodule
